dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between three requesters:
  - memory-stage load port 1 (miss path)
  - memory-stage load port 2 (miss path)
  - the LSQ store-retire path at the LSQ head
- Round-robin arbitration; one outstanding transaction at a time; multi-cycle memory handshake; response timeout watchdog.
- Sits between the memory stage / LSQ commit logic and the data memory. Drives the `data_ready`/`data_response` pairs consumed by the memory stage.

Parameters:
- ADDR_W, 32, address width (matches Address)
- DATA_W, 32, data width (matches MemoryWord)
- TIMEOUT, 255, maximum cycles in BUSY waiting for mem_ack before abort
- CNT_W, 8, watchdog counter width; TIMEOUT < 2^CNT_W

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ld_req1  in  1  load 1 request, level, held until done or squash
- ld_addr1  in  ADDR_W  load 1 address, stable while ld_req1=1
- data_ready1  out  1  one-cycle pulse: load 1 data valid
- data_response1  out  DATA_W  load 1 read data, valid with data_ready1
- ld_req2 / ld_addr2 / data_ready2 / data_response2  same as port 1, for load 2
- st_req  in  1  store-retire request, level
- st_addr  in  ADDR_W  store address
- st_data  in  DATA_W  store data
- st_done  out  1  one-cycle pulse: store written
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_err  out  1  one-cycle pulse on watchdog abort
- busy  out  1  state != IDLE

Behaviour:
- Reset: the synchronous, active-high reset forces the following on the next clk edge, including mid-transaction:
  - state=IDLE, rr_ptr=0, gnt=NONE, cnt=0
  - all outputs 0, including data/address buses
  - an in-flight memory transaction is abandoned; a mem_ack arriving after reset is ignored.
- Requester encoding: 0=store, 1=load1, 2=load2.
- Arbitration (IDLE only):
  - Scan order starts at rr_ptr: rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). The first asserted request wins.
  - Registered grant: gnt <= winner, rr_ptr <= (winner+1) mod 3, state <= BUSY.
  - No requests: stay in IDLE, rr_ptr unchanged.
- BUSY:
  - mem_req=1.
  - mem_we=1 iff gnt=store.
  - mem_addr and mem_wdata are driven from registers captured at grant; requester inputs are not re-sampled.
  - cnt increments each cycle.
  - On mem_ack: capture mem_rdata and go to RESP.
  - If mem_ack is absent and cnt==TIMEOUT-1: go to IDLE with mem_err=1 for one cycle and no done pulse.
  - mem_req is low in every state other than BUSY.
- RESP (exactly one cycle), then IDLE:
  - gnt=load n: data_readyn=1, data_responsen=captured data.
  - gnt=store: st_done=1.
  - Squash: if the granted requester's req is 0 in the RESP cycle (pipeline flush), the pulse is suppressed. The memory write for a store has still occurred.
- Latency: request seen in IDLE at cycle 0 → mem_req at cycle 1 → mem_ack at cycle k≥1 → done pulse at cycle k+1 → IDLE at k+2. Best case: pulse 2 cycles after the request is first seen.
- Response-bus hold:
  - data_response1/2 hold their last value between pulses.
  - Only the granted port's data_response updates.
- Simultaneous events:
  - A request arriving during BUSY/RESP waits for IDLE.
  - mem_ack while IDLE or RESP is ignored.
  - mem_ack in the same cycle as the watchdog limit: the ack wins.
- Requesters may drop req while not granted, without effect.

Decomposition:
- Shared package:
  - `arb_state_t` enum {IDLE, BUSY, RESP}
  - `req_id_t` enum {REQ_ST, REQ_LD1, REQ_LD2, REQ_NONE}
  - `DMEM_TIMEOUT` constant
  - Address/MemoryWord types already shared
- One sub-module, `rr_pick3`: combinational 3-way round-robin picker. Inputs: 3-bit request vector and rr_ptr. Outputs: winner and valid.
- The FSM, watchdog and capture registers stay in `dmem_port_arbiter`.

Test Plan:
- Single load: ld_req1=1, ld_addr1=0x40; memory acks 3 cycles after mem_req with rdata=0xDEADBEEF → mem_we=0, mem_addr=0x40; data_ready1 pulses one cycle after ack with data_response1=0xDEADBEEF; st_done and data_ready2 stay 0.
- Round-robin fairness: st_req, ld_req1 and ld_req2 held high from reset, immediate acks → grant order store, load1, load2, store; each grant spans 3 cycles (BUSY, RESP, IDLE).
- Store write: st_req=1, st_addr=0x80, st_data=0x1234 → mem_we=1, mem_addr=0x80, mem_wdata=0x1234; st_done pulses after ack.
- Squash: ld_req2 granted, ld_req2 dropped before ack → no data_ready2 pulse; the next requester is granted normally.
- Watchdog: load granted, mem_ack never asserted → mem_err pulses after exactly TIMEOUT cycles of mem_req; state returns to IDLE; no data_ready pulse; a late mem_ack is ignored.
- Reset mid-operation: reset asserted in BUSY → next cycle busy=0, mem_req=0, rr_ptr=0; a subsequent ld_req1 and st_req pair grants the store first.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

    localparam int DMEM_TIMEOUT = 255;
    localparam int ADDR_WIDTH   = 32;
    localparam int DATA_WIDTH   = 32;

    typedef logic [ADDR_WIDTH-1:0] address_t;
    typedef logic [DATA_WIDTH-1:0] memory_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Requester ids double as scan positions for the round-robin picker.
    typedef enum logic [1:0] {
        REQ_ST   = 2'd0,
        REQ_LD1  = 2'd1,
        REQ_LD2  = 2'd2,
        REQ_NONE = 2'd3
    } req_id_t;

    // Observation bundle: FSM state, current grant and round-robin pointer.
    typedef struct packed {
        arb_state_t state;
        req_id_t    gnt;
        logic [1:0] rr_ptr;
    } arb_dbg_t;

    // Pointer value that puts the requester after the winner first in line.
    function automatic logic [1:0] rr_next(input req_id_t winner);
        logic [1:0] nxt;
        case (winner)
            REQ_ST:  nxt = 2'd1;
            REQ_LD1: nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: scans rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
module rr_pick3
    import dmem_port_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] rr_ptr,
    output req_id_t    winner,
    output logic       valid
);

    logic [2:0] idx;

    // Walk the scan order backwards so the earliest asserted position wins.
    always_comb begin
        winner = REQ_NONE;
        valid  = 1'b0;
        idx    = 3'd0;
        for (int i = 2; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + 3'(i);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end
            if (req[idx]) begin
                winner = req_id_t'(idx[1:0]);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between two load miss paths and the LSQ
// store-retire path: round-robin grant, one transaction in flight,
// response watchdog.
//
// Handshake: requesters hold req (level) with stable address/data until
// they see their done pulse or withdraw it; the memory sees mem_req high for
// the whole transaction and ends it with a single-cycle mem_ack, with
// mem_rdata valid in that same cycle. Acks outside BUSY are ignored.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_WIDTH,
    parameter int DATA_W  = DATA_WIDTH,
    parameter int TIMEOUT = DMEM_TIMEOUT,
    parameter int CNT_W   = 8
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req1,
    input  logic [ADDR_W-1:0] ld_addr1,
    output logic              data_ready1,
    output logic [DATA_W-1:0] data_response1,
    input  logic              ld_req2,
    input  logic [ADDR_W-1:0] ld_addr2,
    output logic              data_ready2,
    output logic [DATA_W-1:0] data_response2,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic              busy,
    output arb_dbg_t          dbg
);

    arb_state_t        state_q, state_d;
    req_id_t           gnt_q, gnt_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] resp1_q, resp1_d;
    logic [DATA_W-1:0] resp2_q, resp2_d;
    logic              mem_err_q, mem_err_d;

    req_id_t           pick_winner;
    logic              pick_valid;
    logic              in_resp;

    rr_pick3 u_pick (
        .req    ({ld_req2, ld_req1, st_req}),
        .rr_ptr (rr_ptr_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Done pulses fire in RESP only while the granted requester still wants
    // the result; a withdrawn request means the pipeline flushed it.
    assign in_resp     = (state_q == RESP);
    assign data_ready1 = in_resp && (gnt_q == REQ_LD1) && ld_req1;
    assign data_ready2 = in_resp && (gnt_q == REQ_LD2) && ld_req2;
    assign st_done     = in_resp && (gnt_q == REQ_ST)  && st_req;

    // Response buses show fresh data during the pulse and hold otherwise.
    assign data_response1 = data_ready1 ? rdata_q : resp1_q;
    assign data_response2 = data_ready2 ? rdata_q : resp2_q;

    assign mem_req   = (state_q == BUSY);
    assign mem_we    = (state_q == BUSY) && (gnt_q == REQ_ST);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_err   = mem_err_q;
    assign busy      = (state_q != IDLE);
    assign dbg       = '{state: state_q, gnt: gnt_q, rr_ptr: rr_ptr_q};

    // Next-state logic: grant in IDLE, wait/watchdog in BUSY, one-cycle RESP.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp1_d   = resp1_q;
        resp2_d   = resp2_q;
        mem_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d    = pick_winner;
                    rr_ptr_d = rr_next(pick_winner);
                    cnt_d    = '0;
                    state_d  = BUSY;
                    case (pick_winner)
                        REQ_ST: begin
                            addr_d  = st_addr;
                            wdata_d = st_data;
                        end
                        REQ_LD1: begin
                            addr_d  = ld_addr1;
                            wdata_d = '0;
                        end
                        REQ_LD2: begin
                            addr_d  = ld_addr2;
                            wdata_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // An ack on the watchdog's last cycle still completes normally.
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cnt_d     = '0;
                    gnt_d     = REQ_NONE;
                    mem_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (data_ready1) begin
                    resp1_d = rdata_q;
                end
                if (data_ready2) begin
                    resp2_d = rdata_q;
                end
                gnt_d   = REQ_NONE;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = REQ_NONE;
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= REQ_NONE;
            rr_ptr_q  <= 2'd0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp1_q   <= '0;
            resp2_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp1_q   <= resp1_d;
            resp2_q   <= resp2_d;
            mem_err_q <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    localparam int TMO = 255;
    localparam logic [31:0] ADDR_ST = 32'h0000_0080;
    localparam logic [31:0] DATA_ST = 32'h0000_1234;
    localparam logic [31:0] ADDR_L1 = 32'h0000_0040;
    localparam logic [31:0] ADDR_L2 = 32'h0000_0044;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_req1 = 1'b0, ld_req2 = 1'b0, st_req = 1'b0;
    logic [31:0] ld_addr1 = '0, ld_addr2 = '0, st_addr = '0, st_data = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        data_ready1, data_ready2, st_done;
    logic [31:0] data_response1, data_response2;
    logic        mem_req, mem_we, mem_err, busy;
    logic [31:0] mem_addr, mem_wdata;
    arb_dbg_t    dbg;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] hold1 = '0, hold2 = '0;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .ld_req1(ld_req1), .ld_addr1(ld_addr1), .data_ready1(data_ready1), .data_response1(data_response1),
        .ld_req2(ld_req2), .ld_addr2(ld_addr2), .data_ready2(data_ready2), .data_response2(data_response2),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_done(st_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err), .busy(busy), .dbg(dbg)
    );

    // ---------------- clock / global bound ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit");
    end

    // ---------------- driver / checker helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_reqs(input logic [2:0] r);
        st_req  = r[0];
        ld_req1 = r[1];
        ld_req2 = r[2];
    endtask

    task automatic set_fixed_addrs();
        st_addr  = ADDR_ST;
        st_data  = DATA_ST;
        ld_addr1 = ADDR_L1;
        ld_addr2 = ADDR_L2;
    endtask

    function automatic logic [31:0] addr_of(input int w);
        return (w == 0) ? ADDR_ST : (w == 1) ? ADDR_L1 : ADDR_L2;
    endfunction

    // First asserted requester in scan order starting at p.
    function automatic int pick(input bit [2:0] r, input int p);
        for (int i = 0; i < 3; i++) begin
            if (r[(p + i) % 3]) return (p + i) % 3;
        end
        return -1;
    endfunction

    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        set_reqs(3'b000);
        mem_ack = 1'b0;
        mem_rdata = '0;
        next_cycle();
        sample();
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_ready1", data_ready1, 0);
        check("rst_ready2", data_ready2, 0);
        check("rst_st_done", st_done, 0);
        check("rst_resp1", data_response1, 0);
        check("rst_resp2", data_response2, 0);
        check("rst_rr_ptr", dbg.rr_ptr, 0);
        hold1 = '0;
        hold2 = '0;
        next_cycle();
        reset = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  req;      // {ld2, ld1, st} held from the grant cycle
        int          lat;      // BUSY cycles including the ack cycle
        logic [31:0] rdata;
        bit          squash;   // winner withdraws its request before RESP
        int          exp_win;  // 0 store, 1 load1, 2 load2
        bit          exp_pulse;
    } vec_t;

    vec_t vecs[12];

    task automatic run_txn(input vec_t v, input int idx);
        logic [31:0] ea;
        ea = addr_of(v.exp_win);
        next_cycle();
        set_reqs(v.req);
        mem_ack = 1'b0;
        sample();
        check($sformatf("v%0d_idle_busy", idx), busy, 0);
        check($sformatf("v%0d_idle_req", idx), mem_req, 0);
        for (int c = 0; c < v.lat; c++) begin
            next_cycle();
            if (v.squash && c == v.lat - 1) begin
                if (v.exp_win == 0) st_req = 1'b0;
                else if (v.exp_win == 1) ld_req1 = 1'b0;
                else ld_req2 = 1'b0;
            end
            mem_ack = (c == v.lat - 1);
            mem_rdata = mem_ack ? v.rdata : $urandom;
            sample();
            check($sformatf("v%0d_mem_req", idx), mem_req, 1);
            check($sformatf("v%0d_mem_we", idx), mem_we, v.exp_win == 0);
            check($sformatf("v%0d_mem_addr", idx), mem_addr, ea);
            if (v.exp_win == 0) check($sformatf("v%0d_mem_wdata", idx), mem_wdata, DATA_ST);
        end
        next_cycle();
        mem_ack = 1'b0;
        sample();
        check($sformatf("v%0d_resp_req", idx), mem_req, 0);
        check($sformatf("v%0d_st_done", idx), st_done, v.exp_pulse && v.exp_win == 0);
        check($sformatf("v%0d_ready1", idx), data_ready1, v.exp_pulse && v.exp_win == 1);
        check($sformatf("v%0d_ready2", idx), data_ready2, v.exp_pulse && v.exp_win == 2);
        if (v.exp_pulse && v.exp_win == 1) hold1 = v.rdata;
        if (v.exp_pulse && v.exp_win == 2) hold2 = v.rdata;
        if (v.exp_pulse && v.exp_win == 1) check($sformatf("v%0d_resp1", idx), data_response1, v.rdata);
        if (v.exp_pulse && v.exp_win == 2) check($sformatf("v%0d_resp2", idx), data_response2, v.rdata);
        next_cycle();
        set_reqs(3'b000);
        sample();
        check($sformatf("v%0d_after_busy", idx), busy, 0);
        check($sformatf("v%0d_after_ready1", idx), data_ready1, 0);
        check($sformatf("v%0d_after_ready2", idx), data_ready2, 0);
        check($sformatf("v%0d_hold1", idx), data_response1, hold1);
        check($sformatf("v%0d_hold2", idx), data_response2, hold2);
        check($sformatf("v%0d_mem_err", idx), mem_err, 0);
    endtask

    // ---------------- randomized run with reference model ----------------
    int          ph, owner, wait_n, lat_t, ptr;
    bit          req_on[3];
    bit          err_exp;
    logic [31:0] raddr[3];
    logic [31:0] sdata, txn_addr, txn_wdata, txn_rdata;

    task automatic random_cycle();
        bit p0, p1, p2;
        int w;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            if (ph != 0 && i == owner) begin
                if (ph == 1 && req_on[i] && $urandom_range(0, 15) == 0) req_on[i] = 1'b0;
            end else if (req_on[i]) begin
                if ($urandom_range(0, 31) == 0) req_on[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                req_on[i] = 1'b1;
                raddr[i] = (32'(i + 1) << 28) | ($urandom & 32'h0FFF_FFFC);
                if (i == 0) sdata = $urandom;
            end
        end
        st_req = req_on[0]; ld_req1 = req_on[1]; ld_req2 = req_on[2];
        st_addr = raddr[0]; ld_addr1 = raddr[1]; ld_addr2 = raddr[2]; st_data = sdata;
        mem_ack = (ph == 1) ? (wait_n == lat_t) : ($urandom_range(0, 7) == 0);
        mem_rdata = $urandom;
        sample();
        check("r_mem_req", mem_req, ph == 1);
        check("r_busy", busy, ph != 0);
        check("r_mem_err", mem_err, err_exp);
        check("r_rr_ptr", dbg.rr_ptr, ptr);
        if (ph == 1) begin
            check("r_mem_we", mem_we, owner == 0);
            check("r_mem_addr", mem_addr, txn_addr);
            if (owner == 0) check("r_mem_wdata", mem_wdata, txn_wdata);
        end
        p0 = (ph == 2) && (owner == 0) && req_on[0];
        p1 = (ph == 2) && (owner == 1) && req_on[1];
        p2 = (ph == 2) && (owner == 2) && req_on[2];
        if (p1) hold1 = txn_rdata;
        if (p2) hold2 = txn_rdata;
        check("r_st_done", st_done, p0);
        check("r_ready1", data_ready1, p1);
        check("r_ready2", data_ready2, p2);
        check("r_resp1", data_response1, hold1);
        check("r_resp2", data_response2, hold2);
        err_exp = 1'b0;
        case (ph)
            0: begin
                w = pick({req_on[2], req_on[1], req_on[0]}, ptr);
                if (w >= 0) begin
                    owner = w;
                    ptr = (w + 1) % 3;
                    txn_addr = raddr[w];
                    txn_wdata = sdata;
                    wait_n = 0;
                    lat_t = $urandom_range(0, 6);
                    ph = 1;
                end
            end
            1: begin
                if (mem_ack) begin
                    txn_rdata = mem_rdata;
                    ph = 2;
                end else if (wait_n == TMO - 1) begin
                    ph = 0;
                    err_exp = 1'b1;
                end else begin
                    wait_n++;
                end
            end
            default: begin
                req_on[owner] = 1'b0;
                ph = 0;
            end
        endcase
    endtask

    // ---------------- main test ----------------
    initial begin
        int cnt_busy;
        bit early_err;

        vecs[0]  = '{3'b010, 3, 32'hDEAD_BEEF, 1'b0, 1, 1'b1};
        vecs[1]  = '{3'b001, 1, 32'h0000_0000, 1'b0, 0, 1'b1};
        vecs[2]  = '{3'b111, 1, 32'hA1A1_0001, 1'b0, 1, 1'b1};
        vecs[3]  = '{3'b111, 2, 32'hA2A2_0002, 1'b0, 2, 1'b1};
        vecs[4]  = '{3'b111, 1, 32'hA3A3_0003, 1'b0, 0, 1'b1};
        vecs[5]  = '{3'b101, 1, 32'hB0B0_0005, 1'b0, 2, 1'b1};
        vecs[6]  = '{3'b100, 2, 32'hBAD0_0006, 1'b1, 2, 1'b0};
        vecs[7]  = '{3'b110, 1, 32'hC0C0_0007, 1'b0, 1, 1'b1};
        vecs[8]  = '{3'b011, 4, 32'h0000_0008, 1'b0, 0, 1'b1};
        vecs[9]  = '{3'b001, 1, 32'h0000_0009, 1'b1, 0, 1'b0};
        vecs[10] = '{3'b100, 5, 32'hD0D0_000A, 1'b0, 2, 1'b1};
        vecs[11] = '{3'b010, 1, 32'hBAD0_000B, 1'b1, 1, 1'b0};

        set_fixed_addrs();
        do_reset();
        for (int i = 0; i < 12; i++) run_txn(vecs[i], i);

        // Fairness: all three requests held, memory acks every cycle.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            set_reqs(3'b111);
            mem_ack = 1'b1;
            mem_rdata = 32'hF000_0000 + 32'(c);
            sample();
            check("rr_mem_req", mem_req, (c % 3) == 1);
            check("rr_busy", busy, (c % 3) != 0);
            if (c % 3 == 1) begin
                check("rr_addr", mem_addr, addr_of((c / 3) % 3));
                check("rr_we", mem_we, ((c / 3) % 3) == 0);
            end
            if (c % 3 == 2) begin
                check("rr_st_done", st_done, ((c / 3) % 3) == 0);
                check("rr_ready1", data_ready1, ((c / 3) % 3) == 1);
                check("rr_ready2", data_ready2, ((c / 3) % 3) == 2);
                if ((c / 3) % 3 == 1) check("rr_resp1", data_response1, 32'hF000_0000 + 32'(c - 1));
                if ((c / 3) % 3 == 2) check("rr_resp2", data_response2, 32'hF000_0000 + 32'(c - 1));
            end
        end
        next_cycle();
        set_reqs(3'b000);
        mem_ack = 1'b0;

        // Watchdog: load 1 never acknowledged.
        do_reset();
        next_cycle();
        set_reqs(3'b010);
        sample();
        check("wd_idle", busy, 0);
        cnt_busy = 0;
        early_err = 1'b0;
        for (int i = 0; i < 400; i++) begin
            next_cycle();
            if (cnt_busy == TMO) begin
                set_reqs(3'b000);
                mem_ack = 1'b1;
            end
            sample();
            if (!mem_req) break;
            cnt_busy++;
            if (mem_err) early_err = 1'b1;
        end
        check("wd_busy_cycles", cnt_busy, TMO);
        check("wd_early_err", early_err, 0);
        check("wd_err_pulse", mem_err, 1);
        check("wd_busy_after", busy, 0);
        check("wd_no_ready1", data_ready1, 0);
        next_cycle();
        mem_ack = 1'b1;
        sample();
        check("wd_err_once", mem_err, 0);
        check("wd_late_ack_busy", busy, 0);
        check("wd_late_ack_ready1", data_ready1, 0);
        next_cycle();
        mem_ack = 1'b0;

        // Reset in the middle of a load 2 transaction.
        do_reset();
        next_cycle();
        set_reqs(3'b100);
        sample();
        next_cycle();
        sample();
        check("mr_busy_req", mem_req, 1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        set_reqs(3'b000);
        mem_ack = 1'b1;
        sample();
        check("mr_busy", busy, 0);
        check("mr_mem_req", mem_req, 0);
        check("mr_rr_ptr", dbg.rr_ptr, 0);
        check("mr_mem_addr", mem_addr, 0);
        check("mr_ready2", data_ready2, 0);
        next_cycle();
        sample();
        check("mr_ack_ignored", busy, 0);
        next_cycle();
        mem_ack = 1'b0;
        set_reqs(3'b011);
        sample();
        next_cycle();
        sample();
        check("mr_store_first_we", mem_we, 1);
        check("mr_store_first_addr", mem_addr, ADDR_ST);
        check("mr_store_wdata", mem_wdata, DATA_ST);
        next_cycle();
        mem_ack = 1'b1;
        sample();
        next_cycle();
        mem_ack = 1'b0;
        sample();
        check("mr_st_done", st_done, 1);
        check("mr_no_ready1", data_ready1, 0);
        next_cycle();
        set_reqs(3'b000);

        // Randomized traffic.
        do_reset();
        ph = 0; owner = 0; wait_n = 0; lat_t = 0; ptr = 0; err_exp = 1'b0;
        sdata = '0; txn_addr = '0; txn_wdata = '0; txn_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            req_on[i] = 1'b0;
            raddr[i] = '0;
        end
        for (int c = 0; c < 3000; c++) random_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
